// File: rtl/ece453_avalon_arbiter.sv
// ece453_avalon_arbiter: round-robin arbiter sharing one zero-latency Avalon-MM
// register slave between two masters, with a per-grant burst limit under contention.
module ece453_avalon_arbiter #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_waitrequest,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_waitrequest,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic [DATA_W-1:0]   s_readdata,
  output logic                grant_valid,
  output logic                grant_id
);
  typedef enum logic {IDLE, XFER} state_t;
  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic [3:0]  beat_cnt_q, beat_cnt_d;
  logic        req0, req1, req_g, req_o, fwd, acc0, acc1;
  assign req0  = m0_read | m0_write;
  assign req1  = m1_read | m1_write;
  assign req_g = grant_q ? req1 : req0;
  assign req_o = grant_q ? req0 : req1;
  // The owner yields only once it has used its burst and the other master is waiting.
  assign fwd   = (state_q == XFER) & req_g & ~(req_o & (beat_cnt_q == 4'(MAX_BURST)));
  assign acc0  = fwd & ~grant_q;
  assign acc1  = fwd & grant_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= 1'b1;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    if (state_q == IDLE) begin
      if (req0 | req1) begin
        state_d    = XFER;
        grant_d    = (req0 & req1) ? ~grant_q : req1;
        beat_cnt_d = '0;
      end
    end else if (fwd) begin
      beat_cnt_d = (beat_cnt_q == 4'hf) ? beat_cnt_q : beat_cnt_q + 4'd1;
    end else if (req_o) begin
      grant_d    = ~grant_q;
      beat_cnt_d = '0;
    end else begin
      state_d    = IDLE;
    end
  end
  always_comb begin
    s_read         = acc0 ? m0_read : acc1 & m1_read;
    s_write        = acc0 ? m0_write & ~m0_read : acc1 & m1_write & ~m1_read;
    s_address      = acc0 ? m0_address    : acc1 ? m1_address    : '0;
    s_writedata    = acc0 ? m0_writedata  : acc1 ? m1_writedata  : '0;
    s_byteenable   = acc0 ? m0_byteenable : acc1 ? m1_byteenable : '0;
    m0_waitrequest = ~acc0;
    m1_waitrequest = ~acc1;
    m0_readdata    = acc0 ? s_readdata : '0;
    m1_readdata    = acc1 ? s_readdata : '0;
    grant_valid    = state_q == XFER;
    grant_id       = grant_q;
  end
endmodule

// File: tb/tb_ece453_avalon_arbiter.sv
// tb_ece453_avalon_arbiter: directed bench with a memory-backed slave model and
// per-master scoreboards of expected beats.
module tb_ece453_avalon_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] m0_address, m1_address, s_address;
  logic          m0_read, m0_write, m1_read, m1_write, s_read, s_write;
  logic [DW-1:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata, s_writedata, s_readdata;
  logic [3:0]    m0_byteenable, m1_byteenable, s_byteenable;
  logic          m0_waitrequest, m1_waitrequest, grant_valid, grant_id;
  logic [DW-1:0] mem [32];
  int            compared = 0;
  int            mismatched = 0;
  typedef struct {logic [AW-1:0] addr; logic wr; logic [DW-1:0] data;} beat_t;
  beat_t         q0[$], q1[$];
  int            k0, k1, n0, n1, p;
  logic          acc0, acc1;
  logic [DW-1:0] orig;

  always #5 clk = ~clk;

  ece453_avalon_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable), .s_readdata(s_readdata),
    .grant_valid(grant_valid), .grant_id(grant_id)
  );

  // Zero-latency register slave
  assign s_readdata = mem[s_address];
  always @(posedge clk)
    if (s_write)
      for (int b = 0; b < 4; b++)
        if (s_byteenable[b]) mem[s_address][8*b +: 8] <= s_writedata[8*b +: 8];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = 4'hf;
    m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = 4'hf;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_all();
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_s_read"}, s_read, 0);
    chk({pfx, "_s_write"}, s_write, 0);
    chk({pfx, "_s_addr"}, s_address, 0);
    chk({pfx, "_s_wdata"}, s_writedata, 0);
    chk({pfx, "_wait0"}, m0_waitrequest, 1);
    chk({pfx, "_wait1"}, m1_waitrequest, 1);
    chk({pfx, "_rdata0"}, m0_readdata, 0);
    chk({pfx, "_rdata1"}, m1_readdata, 0);
    chk({pfx, "_gvalid"}, grant_valid, 0);
    chk({pfx, "_gid"}, grant_id, 1);
  endtask

  task automatic drv0(input int k);
    m0_address = AW'(k % 16);
    m0_read    = 1;
    q0.push_back('{m0_address, 1'b0, mem[m0_address]});
  endtask

  task automatic drv1(input int k);
    m1_address   = AW'(16 + k % 16);
    m1_write     = 1;
    m1_writedata = 32'hA000 + k;
    q1.push_back('{m1_address, 1'b1, m1_writedata});
  endtask

  task automatic check_accept(input int m);
    beat_t e;
    if ((m == 0 ? q0.size() : q1.size()) == 0) begin
      chk($sformatf("sb%0d_underflow", m), 1, 0);
      return;
    end
    e = (m == 0) ? q0.pop_front() : q1.pop_front();
    chk($sformatf("sb%0d_addr", m), s_address, e.addr);
    chk($sformatf("sb%0d_write", m), s_write, e.wr);
    chk($sformatf("sb%0d_read", m), s_read, !e.wr);
    chk($sformatf("sb%0d_be", m), s_byteenable, 4'hf);
    if (e.wr) chk($sformatf("sb%0d_wdata", m), s_writedata, e.data);
    else      chk($sformatf("sb%0d_rdata", m), m == 0 ? m0_readdata : m1_readdata, e.data);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
    mem[0] = 32'hECE4_5318;
    idle_all();
    reset = 1;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    reset = 0;

    // Single read from IDLE
    next_cycle();
    m0_address = 5'h00; m0_read = 1;
    @(negedge clk);
    chk("rd_c0_wait", m0_waitrequest, 1);
    chk("rd_c0_sread", s_read, 0);
    next_cycle();
    @(negedge clk);
    chk("rd_c1_wait", m0_waitrequest, 0);
    chk("rd_c1_rdata", m0_readdata, 32'hECE4_5318);
    chk("rd_c1_saddr", s_address, 5'h00);
    chk("rd_c1_sread", s_read, 1);
    next_cycle();
    idle_all();
    @(negedge clk);
    chk("rd_c2_sread", s_read, 0);
    chk("rd_c2_wait", m0_waitrequest, 1);

    // Simultaneous first request after reset: m0 wins the tie
    do_reset();
    next_cycle();
    m0_address = 5'h04; m0_write = 1; m0_writedata = 32'h3;
    m1_address = 5'h08; m1_read = 1;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    chk("sim_c1_wait0", m0_waitrequest, 0);
    chk("sim_c1_wait1", m1_waitrequest, 1);
    chk("sim_c1_swrite", s_write, 1);
    chk("sim_c1_wdata", s_writedata, 32'h3);
    chk("sim_c1_saddr", s_address, 5'h04);
    next_cycle();
    m0_write = 0; m0_writedata = '0; m0_address = '0;
    @(negedge clk);
    chk("sim_c2_dead", {s_read, s_write}, 2'b00);
    chk("sim_c2_wait1", m1_waitrequest, 1);
    next_cycle();
    @(negedge clk);
    chk("sim_c3_wait1", m1_waitrequest, 0);
    chk("sim_c3_sread", s_read, 1);
    chk("sim_c3_saddr", s_address, 5'h08);
    chk("sim_c3_rdata", m1_readdata, 32'h1000_0008);
    chk("sim_c3_gid", grant_id, 1);
    next_cycle();
    idle_all();
    @(negedge clk);
    chk("sim_mem4", mem[4], 32'h3);

    // Contention: 4 m0 beats, dead, 4 m1 beats, dead, repeating
    do_reset();
    k0 = 0; k1 = 0; n0 = 0; n1 = 0;
    next_cycle();
    drv0(k0);
    drv1(k1);
    @(negedge clk);
    acc0 = !m0_waitrequest;
    acc1 = !m1_waitrequest;
    chk("bst_c0_idle", {acc0, acc1}, 2'b00);
    for (int k = 1; k <= 30; k++) begin
      next_cycle();
      if (acc0) begin k0++; drv0(k0); end
      if (acc1) begin k1++; drv1(k1); end
      @(negedge clk);
      p = (k - 1) % 10;
      chk($sformatf("bst_k%0d_wait0", k), m0_waitrequest, !(p < 4));
      chk($sformatf("bst_k%0d_wait1", k), m1_waitrequest, !(p >= 5 && p < 9));
      chk($sformatf("bst_k%0d_gid", k), grant_id, p >= 5);
      chk($sformatf("bst_k%0d_gvalid", k), grant_valid, 1);
      acc0 = !m0_waitrequest;
      acc1 = !m1_waitrequest;
      if (acc0) begin n0++; check_accept(0); end
      if (acc1) begin n1++; check_accept(1); end
    end
    chk("bst_n0", n0, 12);
    chk("bst_n1", n1, 12);
    chk("bst_q0_pending", q0.size(), 1);
    chk("bst_q1_pending", q1.size(), 1);
    q0.delete();
    q1.delete();
    next_cycle();
    idle_all();
    repeat (3) next_cycle();
    @(negedge clk);
    chk("bst_back_idle", grant_valid, 0);

    // Uncontended stream: 20 back-to-back m1 writes, counter saturates
    k1 = 0;
    next_cycle();
    drv1(k1);
    @(negedge clk);
    for (int k = 1; k <= 20; k++) begin
      next_cycle();
      if (k > 1) begin k1++; drv1(k1); end
      @(negedge clk);
      chk($sformatf("unc_k%0d_wait1", k), m1_waitrequest, 0);
      chk($sformatf("unc_k%0d_gid", k), grant_id, 1);
      chk($sformatf("unc_k%0d_cnt", k), dut.beat_cnt_q, (k - 1 > 15) ? 15 : k - 1);
      if (!m1_waitrequest) check_accept(1);
    end
    next_cycle();
    idle_all();
    @(negedge clk);
    chk("unc_end_wait1", m1_waitrequest, 1);
    chk("unc_end_cnt", dut.beat_cnt_q, 15);
    chk("unc_q1_empty", q1.size(), 0);
    chk("unc_mem19", mem[19], 32'hA000 + 19);
    repeat (3) next_cycle();

    // Read and write both high: read wins, register untouched
    orig = mem[3];
    m0_address = 5'h03; m0_read = 1; m0_write = 1; m0_writedata = 32'hDEAD_BEEF;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    chk("rw_sread", s_read, 1);
    chk("rw_swrite", s_write, 0);
    chk("rw_wait0", m0_waitrequest, 0);
    chk("rw_rdata", m0_readdata, orig);
    next_cycle();
    idle_all();
    @(negedge clk);
    chk("rw_mem3", mem[3], orig);

    // Asynchronous reset in the middle of an accepted read
    repeat (2) next_cycle();
    m0_address = 5'h01; m0_read = 1;
    next_cycle();
    @(negedge clk);
    chk("mrst_pre_sread", s_read, 1);
    next_cycle();
    #1;
    reset = 1;
    #1;
    check_reset_vals("mrst");
    @(negedge clk);
    reset = 0;
    idle_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
